// File: rtl/alu_md.sv
// Multi-cycle integer ALU with RV32M multiply/divide.
// Iterative radix-2 units behind valid/ready handshakes.
module alu_md #(
  parameter int REG_WIDTH = 32,
  parameter int SHAMT_W   = $clog2(REG_WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_WIDTH-1:0] in1,
  input  logic [REG_WIDTH-1:0] in2,
  input  logic [4:0]           alu_control,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] result,
  output logic                 zero,
  output logic                 sign,
  output logic                 busy
);

  localparam int W  = REG_WIDTH;
  localparam int CW = $clog2(W) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [1:0]    op_lo;
  logic [2*W-1:0] acc;
  logic [W-1:0]  mag;
  logic [CW-1:0] cnt;
  logic          neg;

  logic          is_mul;
  logic          is_div;
  logic          is_rem;
  logic          sa;
  logic          sb;
  logic [W-1:0]  abs_a;
  logic [W-1:0]  abs_b;
  logic          div_zero;
  logic          div_ovf;
  logic [W-1:0]  base_res;
  logic [SHAMT_W-1:0] shamt;

  assign is_mul   = alu_control[4:2] == 3'b100;
  assign is_div   = alu_control[4:2] == 3'b101;
  assign is_rem   = alu_control[1];
  assign shamt    = in2[SHAMT_W-1:0];
  assign div_zero = in2 == '0;
  assign div_ovf  = !alu_control[0]
                 && in1 == {1'b1, {(W-1){1'b0}}}
                 && in2 == '1;

  // Signedness of each operand for the M-group magnitude path
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    if (is_mul) begin
      sa = alu_control[1:0] == 2'b01
        || alu_control[1:0] == 2'b10;
      sb = alu_control[1:0] == 2'b01;
    end else if (is_div) begin
      sa = !alu_control[0];
      sb = !alu_control[0];
    end
  end

  assign abs_a = (sa && in1[W-1]) ? -in1 : in1;
  assign abs_b = (sb && in2[W-1]) ? -in2 : in2;

  always_comb begin
    base_res = in1 + in2;
    case (alu_control)
      5'b00000: base_res = in1 & in2;
      5'b00001: base_res = in1 | in2;
      5'b00011: base_res = in1 ^ in2;
      5'b00100: base_res = in1 << shamt;
      5'b00101: base_res = in1 >> shamt;
      5'b00110: base_res = $signed(in1) >>> shamt;
      5'b00111: base_res = in1 - in2;
      5'b01000:
        base_res = {{(W-1){1'b0}},
                    $signed(in1) < $signed(in2)};
      5'b01001:
        base_res = {{(W-1){1'b0}}, in1 < in2};
      5'b01010: base_res = in1 | in2;
      default:  base_res = in1 + in2;
    endcase
  end

  // Shift-add step: multiplier sits in the low half of acc
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [2*W-1:0] mul_fix;

  assign mul_sum  = {1'b0, acc[2*W-1:W]}
                  + {1'b0, (acc[0] ? mag : {W{1'b0}})};
  assign mul_next = {mul_sum, acc[W-1:1]};
  assign mul_fix  = neg ? -mul_next : mul_next;

  // Restoring step: acc = {remainder, dividend/quotient}
  logic [W:0]     div_trial;
  logic [2*W-1:0] div_next;
  logic [W-1:0]   div_val;
  logic [W-1:0]   div_fix;

  assign div_trial = acc[2*W-1:W-1] - {1'b0, mag};
  assign div_next  = div_trial[W]
                   ? {acc[2*W-2:0], 1'b0}
                   : {div_trial[W-1:0], acc[W-2:0], 1'b1};
  assign div_val   = op_lo[1] ? div_next[2*W-1:W]
                              : div_next[W-1:0];
  assign div_fix   = neg ? -div_val : div_val;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      op_lo  <= '0;
      acc    <= '0;
      mag    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_lo <= alu_control[1:0];
          cnt   <= '0;
          if (is_mul) begin
            acc   <= {{W{1'b0}}, abs_b};
            mag   <= abs_a;
            neg   <= (sa & in1[W-1]) ^ (sb & in2[W-1]);
            state <= S_MUL;
          end else if (is_div && div_zero) begin
            result <= is_rem ? in1 : '1;
            state  <= S_DONE;
          end else if (is_div && div_ovf) begin
            result <= is_rem ? '0 : in1;
            state  <= S_DONE;
          end else if (is_div) begin
            acc   <= {{W{1'b0}}, abs_a};
            mag   <= abs_b;
            neg   <= sa & (is_rem ? in1[W-1]
                                  : in1[W-1] ^ in2[W-1]);
            state <= S_DIV;
          end else begin
            result <= base_res;
            state  <= S_DONE;
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W-1)) begin
            result <= (op_lo == 2'b00) ? mul_fix[W-1:0]
                                       : mul_fix[2*W-1:W];
            state  <= S_DONE;
          end
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(W-1)) begin
            result <= div_fix;
            state  <= S_DONE;
          end
        end
        default: if (out_ready) state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = state == S_IDLE;
  assign out_valid = state == S_DONE;
  assign busy      = state == S_MUL || state == S_DIV;
  assign zero      = result == '0;
  assign sign      = result[W-1];

endmodule

// File: tb/tb_alu_md.sv
// Directed vector bench for alu_md.
// Covers base ops, M group, special cases, backpressure.
module tb_alu_md;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [4:0]  alu_control;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        sign;
  logic        busy;

  logic        v16_in;
  logic        r16_in;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [4:0]  op16;
  logic        v16_out;
  logic        r16_out;
  logic [15:0] res16;
  logic        z16;
  logic        s16;
  logic        busy16;

  int n_chk  = 0;
  int n_fail = 0;

  alu_md #(.REG_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .sign(sign),
    .busy(busy)
  );

  alu_md #(.REG_WIDTH(16)) dut16 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(v16_in), .in_ready(r16_in),
    .in1(a16), .in2(b16), .alu_control(op16),
    .out_valid(v16_out), .out_ready(r16_out),
    .result(res16), .zero(z16), .sign(s16),
    .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          bsy;
    logic        z;
    logic        s;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic add_vec(input string name,
                         input logic [4:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] exp,
                         input int lat);
    vec_t v;
    v.name = name;
    v.op   = op;
    v.a    = a;
    v.b    = b;
    v.exp  = exp;
    v.lat  = lat;
    v.bsy  = (lat > 1) ? lat - 1 : 0;
    v.z    = exp == 32'h0;
    v.s    = exp[31];
    vecs.push_back(v);
  endtask

  task automatic do_op(input logic [4:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [31:0] res,
                       output int lat,
                       output int bsy,
                       output logic z,
                       output logic s);
    in_valid    = 1'b1;
    alu_control = op;
    in1         = a;
    in2         = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in1      = 32'hDEAD_BEEF;
    in2      = 32'h1234_5678;
    lat = 1;
    bsy = 0;
    while (!out_valid && lat < 200) begin
      if (busy) bsy++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    z   = zero;
    s   = sign;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op16(input logic [4:0] op,
                         input logic [15:0] a,
                         input logic [15:0] b,
                         output logic [15:0] res,
                         output int lat);
    v16_in = 1'b1;
    op16   = op;
    a16    = a;
    b16    = b;
    @(posedge clk);
    #1;
    v16_in = 1'b0;
    lat = 1;
    while (!v16_out && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = res16;
    r16_out = 1'b1;
    @(posedge clk);
    #1;
    r16_out = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [15:0] r16;
    logic        z;
    logic        s;
    int          lat;
    int          bsy;

    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in1         = '0;
    in2         = '0;
    alu_control = '0;
    out_ready   = 1'b0;
    v16_in      = 1'b0;
    a16         = '0;
    b16         = '0;
    op16        = '0;
    r16_out     = 1'b0;

    add_vec("add_ovf", 5'b00010, 32'h7FFFFFFF, 32'h1,
            32'h80000000, 1);
    add_vec("sra", 5'b00110, 32'h80000000, 32'h24,
            32'hF8000000, 1);
    add_vec("sltu", 5'b01001, 32'h1, 32'hFFFFFFFF,
            32'h1, 1);
    add_vec("slt", 5'b01000, 32'hFFFFFFFF, 32'h1,
            32'h1, 1);
    add_vec("sub_wrap", 5'b00111, 32'h0, 32'h1,
            32'hFFFFFFFF, 1);
    add_vec("sll", 5'b00100, 32'h1, 32'h21,
            32'h2, 1);
    add_vec("srl", 5'b00101, 32'h80000000, 32'h4,
            32'h08000000, 1);
    add_vec("and", 5'b00000, 32'hF0F0F0F0, 32'hFF00FF00,
            32'hF000F000, 1);
    add_vec("lui_or", 5'b01010, 32'h12345000, 32'h0,
            32'h12345000, 1);
    add_vec("xor", 5'b00011, 32'hAAAAAAAA, 32'hFFFFFFFF,
            32'h55555555, 1);
    add_vec("dflt_add", 5'b11111, 32'h5, 32'h6,
            32'hB, 1);
    add_vec("mul", 5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h1, 33);
    add_vec("mulh", 5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h0, 33);
    add_vec("mulhu", 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 33);
    add_vec("mulhsu", 5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFF, 33);
    add_vec("mul_neg", 5'b10000, 32'h7, 32'hFFFFFFFD,
            32'hFFFFFFEB, 33);
    add_vec("div", 5'b10100, 32'hFFFFFFF9, 32'h2,
            32'hFFFFFFFD, 33);
    add_vec("rem", 5'b10110, 32'hFFFFFFF9, 32'h2,
            32'hFFFFFFFF, 33);
    add_vec("divu", 5'b10101, 32'd100, 32'd7,
            32'd14, 33);
    add_vec("remu", 5'b10111, 32'd100, 32'd7,
            32'd2, 33);
    add_vec("div_by0", 5'b10100, 32'd5, 32'd0,
            32'hFFFFFFFF, 1);
    add_vec("divu_by0", 5'b10101, 32'd5, 32'd0,
            32'hFFFFFFFF, 1);
    add_vec("remu_by0", 5'b10111, 32'd5, 32'd0,
            32'd5, 1);
    add_vec("rem_by0", 5'b10110, 32'hFFFFFFF0, 32'd0,
            32'hFFFFFFF0, 1);
    add_vec("div_ovf", 5'b10100, 32'h80000000,
            32'hFFFFFFFF, 32'h80000000, 1);
    add_vec("rem_ovf", 5'b10110, 32'h80000000,
            32'hFFFFFFFF, 32'h0, 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", 32'(zero), 32'h1);
    chk("rst_sign", 32'(sign), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b,
            res, lat, bsy, z, s);
      chk({vecs[i].name, "_res"}, res, vecs[i].exp);
      chk({vecs[i].name, "_lat"}, 32'(lat),
          32'(vecs[i].lat));
      chk({vecs[i].name, "_busy"}, 32'(bsy),
          32'(vecs[i].bsy));
      chk({vecs[i].name, "_zero"}, 32'(z),
          32'(vecs[i].z));
      chk({vecs[i].name, "_sign"}, 32'(s),
          32'(vecs[i].s));
    end

    // Backpressure while DONE, inputs wiggling
    in_valid    = 1'b1;
    alu_control = 5'b10000;
    in1         = 32'd3;
    in2         = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 5; i++) begin
      in1         = $urandom;
      in2         = $urandom;
      in_valid    = i[0];
      alu_control = 5'b00010;
      @(posedge clk);
      #1;
      chk("bp_result", result, 32'd15);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_valid", 32'(out_valid), 32'h1);
    end
    in_valid    = 1'b1;
    alu_control = 5'b00010;
    in1         = 32'd10;
    in2         = 32'd20;
    out_ready   = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_idle_ready", 32'(in_ready), 32'h1);
    chk("bp_idle_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 32'h1);
    chk("bp_next_res", result, 32'd30);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Reset in the middle of a multiply
    in_valid    = 1'b1;
    alu_control = 5'b10011;
    in1         = 32'hFFFF;
    in2         = 32'hFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'h1);
    reset_n = 1'b0;
    #2;
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_out_valid", 32'(out_valid), 32'h0);
    chk("rel_in_ready", 32'(in_ready), 32'h1);
    chk("rel_result", result, 32'h0);
    chk("rel_zero", 32'(zero), 32'h1);
    chk("rel_busy", 32'(busy), 32'h0);
    repeat (40) @(posedge clk);
    #1;
    chk("rel_no_stale", 32'(out_valid), 32'h0);

    // Narrow instance
    do_op16(5'b10000, 16'hFFFF, 16'hFFFF, r16, lat);
    chk("w16_mul_res", 32'(r16), 32'h1);
    chk("w16_mul_lat", 32'(lat), 32'd17);
    do_op16(5'b10011, 16'hFFFF, 16'hFFFF, r16, lat);
    chk("w16_mulhu_res", 32'(r16), 32'hFFFE);
    do_op16(5'b10100, 16'hFFF9, 16'h2, r16, lat);
    chk("w16_div_res", 32'(r16), 32'hFFFD);
    chk("w16_div_lat", 32'(lat), 32'd17);
    do_op16(5'b00110, 16'h8000, 16'h24, r16, lat);
    chk("w16_sra_res", 32'(r16), 32'hF800);
    chk("w16_sra_lat", 32'(lat), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
